// File: rtl/uart_reg_fifo_bridge.sv
// Bridges core valid/ready byte streams to a 16550-style register port.
// Every data access is preceded by an LSR poll. TX and RX share the port, and a toggling priority bit decides when both are ready.
module uart_reg_fifo_bridge #(
  parameter int DATA_W    = 8,
  parameter int ADDR_W    = 3,
  parameter int RD_LAT    = 4,
  parameter int TXF_DEPTH = 4,
  parameter int RXF_DEPTH = 4,
  parameter int REG_DATA  = 0,
  parameter int REG_LSR   = 5,
  parameter int LSR_DR    = 0,
  parameter int LSR_OE    = 1,
  parameter int LSR_TEMT  = 6,
  localparam int TXA = $clog2(TXF_DEPTH),
  localparam int RXA = $clog2(RXF_DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              tx_valid,
  input  logic [DATA_W-1:0] tx_data,
  output logic              tx_ready,
  output logic              rx_valid,
  output logic [DATA_W-1:0] rx_data,
  input  logic              rx_ready,
  output logic              ovr,
  input  logic              ovr_clr,
  output logic              i_tx_en,
  output logic [ADDR_W-1:0] waddr,
  output logic [DATA_W-1:0] wdata,
  output logic              i_rx_en,
  output logic [ADDR_W-1:0] raddr,
  input  logic [DATA_W-1:0] rdata,
  output logic [TXA:0]      tx_level,
  output logic [RXA:0]      rx_level
);
  localparam int CW = $clog2(RD_LAT + 1);

  typedef enum logic [2:0] {POLL, PWAIT, EVAL, WR, RD, RWAIT, RCAP} state_t;
  state_t state, state_nxt;

  logic [CW-1:0]     cnt;
  logic              prio;
  logic              rx_ok, tx_ok;
  logic [DATA_W-1:0] tx_mem [TXF_DEPTH];
  logic [DATA_W-1:0] rx_mem [RXF_DEPTH];
  logic [TXA:0]      tx_wp, tx_rp;
  logic [RXA:0]      rx_wp, rx_rp;
  logic              tx_push, tx_pop, rx_push, rx_pop;

  assign tx_ready = !rst && (tx_level != (TXA+1)'(TXF_DEPTH));
  assign rx_valid = (rx_level != '0);
  assign rx_data  = rx_valid ? rx_mem[rx_rp[RXA-1:0]] : '0;

  assign tx_push = tx_valid && tx_ready;
  assign tx_pop  = (state == WR);
  assign rx_push = (state == RCAP);
  assign rx_pop  = rx_valid && rx_ready;

  // rdata holds the LSR value only while in EVAL; these terms are consumed there alone.
  assign rx_ok = rdata[LSR_DR] && (rx_level < (RXA+1)'(RXF_DEPTH));
  assign tx_ok = rdata[LSR_TEMT] && (tx_level != '0);

  always_comb begin
    state_nxt = state;
    case (state)
      POLL:  state_nxt = PWAIT;
      PWAIT: if (cnt == CW'(RD_LAT-1)) state_nxt = EVAL;
      EVAL: begin
        if (rx_ok && tx_ok) state_nxt = prio ? WR : RD;
        else if (rx_ok)     state_nxt = RD;
        else if (tx_ok)     state_nxt = WR;
        else                state_nxt = POLL;
      end
      WR:    state_nxt = POLL;
      RD:    state_nxt = RWAIT;
      RWAIT: if (cnt == CW'(RD_LAT-1)) state_nxt = RCAP;
      RCAP:  state_nxt = POLL;
      default: state_nxt = POLL;
    endcase
  end

  // Strobes are registered, so a strobe appears in the cycle after the issuing state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= POLL;
      cnt     <= '0;
      prio    <= 1'b0;
      ovr     <= 1'b0;
      i_tx_en <= 1'b0;
      i_rx_en <= 1'b0;
      waddr   <= '0;
      raddr   <= '0;
      wdata   <= '0;
    end else begin
      state   <= state_nxt;
      i_tx_en <= (state == WR);
      i_rx_en <= (state == POLL) || (state == RD);
      if (state == POLL) raddr <= ADDR_W'(REG_LSR);
      if (state == RD)   raddr <= ADDR_W'(REG_DATA);
      if (state == WR) begin
        waddr <= ADDR_W'(REG_DATA);
        wdata <= tx_mem[tx_rp[TXA-1:0]];
      end
      if (state == POLL || state == RD)         cnt <= '0;
      else if (state == PWAIT || state == RWAIT) cnt <= cnt + CW'(1);
      if (state == EVAL && rx_ok && tx_ok) prio <= !prio;
      if (state == EVAL && rdata[LSR_OE]) ovr <= 1'b1;
      else if (ovr_clr)                   ovr <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (tx_push) tx_mem[tx_wp[TXA-1:0]] <= tx_data;
    if (rx_push) rx_mem[rx_wp[RXA-1:0]] <= rdata;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      tx_wp    <= '0;
      tx_rp    <= '0;
      tx_level <= '0;
      rx_wp    <= '0;
      rx_rp    <= '0;
      rx_level <= '0;
    end else begin
      if (tx_push) tx_wp <= tx_wp + 1'b1;
      if (tx_pop)  tx_rp <= tx_rp + 1'b1;
      case ({tx_push, tx_pop})
        2'b10:   tx_level <= tx_level + 1'b1;
        2'b01:   tx_level <= tx_level - 1'b1;
        default: tx_level <= tx_level;
      endcase
      if (rx_push) rx_wp <= rx_wp + 1'b1;
      if (rx_pop)  rx_rp <= rx_rp + 1'b1;
      case ({rx_push, rx_pop})
        2'b10:   rx_level <= rx_level + 1'b1;
        2'b01:   rx_level <= rx_level - 1'b1;
        default: rx_level <= rx_level;
      endcase
    end
  end
endmodule
